// File: rtl/wb_stage.sv
// Write-back stage: commits GPR results, owns the architectural CSR file,
// performs exception entry / ERTN return and drives the pipeline flush.
module wb_stage #(
    parameter int MS_TO_WS_BUS_WD = 167,
    parameter int WS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [WS_FWD_BUS_WD-1:0]   ws_fwd_bus,
    output logic                       ws_flush_pipe,
    output logic [31:0]                ws_flush_target,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;

    logic                       ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_bus_r;

    logic [8:0]  bus_subecode;
    logic        bus_ex;
    logic        bus_ertn;
    logic [31:0] bus_csr_wvalue;
    logic [5:0]  bus_ecode;
    logic        bus_csr_re;
    logic        bus_csr_we;
    logic [13:0] bus_csr_num;
    logic [31:0] bus_csr_wmask;
    logic        bus_gr_we;
    logic [4:0]  bus_dest;
    logic [31:0] bus_result;
    logic [31:0] bus_pc;

    // CSR state
    logic        crmd_da;
    logic        crmd_ie;
    logic [1:0]  crmd_plv;
    logic        prmd_pie;
    logic [1:0]  prmd_pplv;
    logic [1:0]  estat_is;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [25:0] eentry_va;
    logic [31:0] save0;
    logic [31:0] save1;
    logic [31:0] save2;
    logic [31:0] save3;

    logic        ex_commit;
    logic        ertn_commit;
    logic        csr_wr;
    logic [31:0] csr_rvalue;
    logic [31:0] final_data;
    logic [31:0] save_new;
    logic [3:0]  crmd_new;
    logic [2:0]  prmd_new;
    logic [1:0]  estat_new;
    logic [31:0] era_new;
    logic [25:0] eentry_new;

    // The stage never stalls, so it always accepts what memory offers.
    assign ws_allowin = 1'b1;

    // Stage valid tracks the upstream valid every cycle; payload only on valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            ms_bus_r <= '0;
        end else begin
            ws_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                ms_bus_r <= ms_to_ws_bus;
            end
        end
    end

    assign {bus_subecode, bus_ex, bus_ertn, bus_csr_wvalue, bus_ecode,
            bus_csr_re, bus_csr_we, bus_csr_num, bus_csr_wmask,
            bus_gr_we, bus_dest, bus_result, bus_pc} = ms_bus_r;

    assign ex_commit   = ws_valid && bus_ex;
    assign ertn_commit = ws_valid && bus_ertn && !ex_commit;
    assign csr_wr      = ws_valid && bus_csr_we && !bus_ex;

    // Combinational CSR read mux; unimplemented numbers read as zero.
    always_comb begin
        csr_rvalue = 32'h0;
        case (bus_csr_num)
            CSR_CRMD:   csr_rvalue = {28'h0, crmd_da, crmd_ie, crmd_plv};
            CSR_PRMD:   csr_rvalue = {29'h0, prmd_pie, prmd_pplv};
            CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 14'h0, estat_is};
            CSR_ERA:    csr_rvalue = era;
            CSR_EENTRY: csr_rvalue = {eentry_va, 6'h0};
            CSR_SAVE0:  csr_rvalue = save0;
            CSR_SAVE1:  csr_rvalue = save1;
            CSR_SAVE2:  csr_rvalue = save2;
            CSR_SAVE3:  csr_rvalue = save3;
            default:    csr_rvalue = 32'h0;
        endcase
    end

    // Masked merges of the write value into each register's writable bits.
    assign save_new   = (csr_rvalue & ~bus_csr_wmask) | (bus_csr_wvalue & bus_csr_wmask);
    assign crmd_new   = ({crmd_da, crmd_ie, crmd_plv} & ~bus_csr_wmask[3:0])
                      | (bus_csr_wvalue[3:0] & bus_csr_wmask[3:0]);
    assign prmd_new   = ({prmd_pie, prmd_pplv} & ~bus_csr_wmask[2:0])
                      | (bus_csr_wvalue[2:0] & bus_csr_wmask[2:0]);
    assign estat_new  = (estat_is & ~bus_csr_wmask[1:0])
                      | (bus_csr_wvalue[1:0] & bus_csr_wmask[1:0]);
    assign era_new    = save_new;
    assign eentry_new = (eentry_va & ~bus_csr_wmask[31:6])
                      | (bus_csr_wvalue[31:6] & bus_csr_wmask[31:6]);

    // CRMD: exception drops to kernel with interrupts off, ERTN restores from PRMD.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_da  <= 1'b1;
            crmd_ie  <= 1'b0;
            crmd_plv <= 2'b00;
        end else if (ex_commit) begin
            crmd_plv <= 2'b00;
            crmd_ie  <= 1'b0;
        end else begin
            if (csr_wr && bus_csr_num == CSR_CRMD) begin
                {crmd_da, crmd_ie, crmd_plv} <= crmd_new;
            end
            if (ertn_commit) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end
        end
    end

    // PRMD: snapshot of CRMD privilege and interrupt enable at exception entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            prmd_pie  <= 1'b0;
            prmd_pplv <= 2'b00;
        end else if (ex_commit) begin
            prmd_pplv <= crmd_plv;
            prmd_pie  <= crmd_ie;
        end else if (csr_wr && bus_csr_num == CSR_PRMD) begin
            {prmd_pie, prmd_pplv} <= prmd_new;
        end
    end

    // ESTAT: exception codes come from hardware only; software may set IS bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            estat_is       <= 2'b00;
            estat_ecode    <= 6'h0;
            estat_esubcode <= 9'h0;
        end else if (ex_commit) begin
            estat_ecode    <= bus_ecode;
            estat_esubcode <= bus_subecode;
        end else if (csr_wr && bus_csr_num == CSR_ESTAT) begin
            estat_is <= estat_new;
        end
    end

    // ERA: captures the faulting PC so ERTN can return to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            era <= 32'h0;
        end else if (ex_commit) begin
            era <= bus_pc;
        end else if (csr_wr && bus_csr_num == CSR_ERA) begin
            era <= era_new;
        end
    end

    // EENTRY: software-programmed, 64-byte aligned exception vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            eentry_va <= 26'h0;
        end else if (csr_wr && bus_csr_num == CSR_EENTRY) begin
            eentry_va <= eentry_new;
        end
    end

    // SAVE0-3 scratch registers have no reset value but must not change under reset.
    always_ff @(posedge clk) begin
        if (!reset && csr_wr) begin
            case (bus_csr_num)
                CSR_SAVE0: save0 <= save_new;
                CSR_SAVE1: save1 <= save_new;
                CSR_SAVE2: save2 <= save_new;
                CSR_SAVE3: save3 <= save_new;
                default:   ;
            endcase
        end
    end

    // Commit and forwarding path; a CSR read returns the pre-update value.
    assign final_data = bus_csr_re ? csr_rvalue : bus_result;
    assign rf_we      = ws_valid && bus_gr_we && !bus_ex;
    assign rf_waddr   = bus_dest;
    assign rf_wdata   = final_data;
    assign ws_fwd_bus = {bus_csr_re && ws_valid, ws_valid && bus_gr_we, bus_dest, final_data};

    // Redirect: exception vector has priority, ERTN returns to the old ERA.
    always_comb begin
        ws_flush_pipe   = ex_commit || ertn_commit;
        ws_flush_target = 32'h0;
        if (ex_commit) begin
            ws_flush_target = {eentry_va, 6'h0};
        end else if (ertn_commit) begin
            ws_flush_target = era;
        end
    end

    assign debug_wb_pc       = bus_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever an instruction sits in WB.
module tb_wb_stage;

    logic         clk;
    logic         reset;
    logic         ms_to_ws_valid;
    logic [166:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [38:0]  ws_fwd_bus;
    logic         ws_flush_pipe;
    logic [31:0]  ws_flush_target;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    typedef struct {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        flush;
        logic [31:0] target;
        logic [1:0]  fwd_hi;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    logic issued_d;

    wb_stage #(.MS_TO_WS_BUS_WD(167), .WS_FWD_BUS_WD(39)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_bus        (ws_fwd_bus),
        .ws_flush_pipe     (ws_flush_pipe),
        .ws_flush_target   (ws_flush_target),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one instruction into WB and record what it must produce.
    task automatic applyStimulus(
        input logic        ex, input logic ertn, input logic [5:0] ecode, input logic [8:0] subecode,
        input logic        csr_re, input logic csr_we, input logic [13:0] csr_num,
        input logic [31:0] wvalue, input logic [31:0] wmask,
        input logic        gr_we, input logic [4:0] dest, input logic [31:0] result, input logic [31:0] pc,
        input logic        e_rf_we, input logic [31:0] e_wdata, input logic e_flush, input logic [31:0] e_target);
        exp_t e;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus = {subecode, ex, ertn, wvalue, ecode, csr_re, csr_we, csr_num,
                        wmask, gr_we, dest, result, pc};
        e.rf_we  = e_rf_we;
        e.waddr  = dest;
        e.wdata  = e_wdata;
        e.flush  = e_flush;
        e.target = e_target;
        e.fwd_hi = {csr_re, gr_we};
        e.pc     = pc;
        exp_q.push_back(e);
    endtask

    task automatic csrRead(input logic [13:0] num, input logic [4:0] dest, input logic [31:0] pc, input logic [31:0] expv);
        applyStimulus(0, 0, 0, 0, 1, 0, num, 0, 0, 1, dest, 32'hDEAD_BEEF, pc, 1, expv, 0, 0);
    endtask

    task automatic csrWrite(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask, input logic [31:0] pc);
        applyStimulus(0, 0, 0, 0, 0, 1, num, val, mask, 0, 0, 32'h0, pc, 0, 32'h0, 0, 0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_rf_we"}, {31'h0, rf_we}, 32'h0);
        checkOutput({tag, "_flush"}, {31'h0, ws_flush_pipe}, 32'h0);
        checkOutput({tag, "_target"}, ws_flush_target, 32'h0);
        checkOutput({tag, "_fwd_hi"}, {30'h0, ws_fwd_bus[38:37]}, 32'h0);
        checkOutput({tag, "_dbg_we"}, {28'h0, debug_wb_rf_we}, 32'h0);
    endtask

    // Tracks which cycles hold an instruction in WB.
    always @(posedge clk) begin
        issued_d <= reset ? 1'b0 : ms_to_ws_valid;
    end

    // Monitor: compare each WB-resident instruction against the scoreboard head.
    always @(negedge clk) begin
        if (issued_d) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard: got output with no expectation queued, expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rf_we", {31'h0, rf_we}, {31'h0, e.rf_we});
                checkOutput("dbg_rf_we", {28'h0, debug_wb_rf_we}, {28'h0, {4{e.rf_we}}});
                checkOutput("rf_waddr", {27'h0, rf_waddr}, {27'h0, e.waddr});
                checkOutput("dbg_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, e.waddr});
                checkOutput("rf_wdata", rf_wdata, e.wdata);
                checkOutput("dbg_wdata", debug_wb_rf_wdata, e.wdata);
                checkOutput("fwd_hi", {30'h0, ws_fwd_bus[38:37]}, {30'h0, e.fwd_hi});
                checkOutput("fwd_data", ws_fwd_bus[31:0], e.wdata);
                checkOutput("fwd_dest", {27'h0, ws_fwd_bus[36:32]}, {27'h0, e.waddr});
                checkOutput("flush", {31'h0, ws_flush_pipe}, {31'h0, e.flush});
                checkOutput("target", ws_flush_target, e.target);
                checkOutput("dbg_pc", debug_wb_pc, e.pc);
            end
        end
    end

    // Directed sequence.
    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset_pc", debug_wb_pc, 32'h0);
        checkOutput("allowin", {31'h0, ws_allowin}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        csrRead(14'h000, 5'd1, 32'h1C00_0000, 32'h0000_0008);
        applyStimulus(0, 0, 0, 0, 0, 0, 14'h0, 0, 0, 1, 5'd5, 32'h0000_1234, 32'h1C00_0004,
                      1, 32'h0000_1234, 0, 0);
        csrWrite(14'h031, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1C00_0008);
        csrWrite(14'h031, 32'hFFFF_0000, 32'h00FF_00FF, 32'h1C00_000C);
        csrRead(14'h031, 5'd2, 32'h1C00_0010, 32'h12FF_5600);
        csrWrite(14'h000, 32'h0000_0007, 32'h0000_000F, 32'h1C00_0014);
        csrWrite(14'h00C, 32'h1C00_0100, 32'hFFFF_FFFF, 32'h1C00_0018);
        csrRead(14'h000, 5'd4, 32'h1C00_001C, 32'h0000_0007);
        csrRead(14'h00C, 5'd4, 32'h1C00_0020, 32'h1C00_0100);
        // Exception that also carries a SAVE1 write: the write must be dropped.
        applyStimulus(1, 0, 6'h0B, 9'h0, 0, 1, 14'h031, 32'h0, 32'hFFFF_FFFF, 1, 5'd3, 32'h0000_DEAD,
                      32'h1C00_0040, 0, 32'h0000_DEAD, 1, 32'h1C00_0100);
        csrRead(14'h000, 5'd6, 32'h1C00_0100, 32'h0000_0000);
        csrRead(14'h001, 5'd6, 32'h1C00_0104, 32'h0000_0007);
        csrRead(14'h006, 5'd6, 32'h1C00_0108, 32'h1C00_0040);
        csrRead(14'h005, 5'd6, 32'h1C00_010C, 32'h000B_0000);
        csrRead(14'h031, 5'd6, 32'h1C00_0110, 32'h12FF_5600);
        applyStimulus(0, 1, 0, 0, 0, 0, 14'h0, 0, 0, 0, 5'd0, 32'h0, 32'h1C00_0114,
                      0, 32'h0, 1, 32'h1C00_0040);
        csrRead(14'h000, 5'd7, 32'h1C00_0040, 32'h0000_0007);
        csrRead(14'h007, 5'd7, 32'h1C00_0044, 32'h0000_0000);
        csrWrite(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1C00_0048);
        csrRead(14'h005, 5'd8, 32'h1C00_004C, 32'h000B_0003);
        // Exception whose WB cycle coincides with reset being raised.
        applyStimulus(1, 0, 6'h05, 9'h1, 0, 0, 14'h0, 0, 0, 0, 5'd0, 32'h0, 32'h1C00_0200,
                      0, 32'h0, 1, 32'h1C00_0100);
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkQuiet("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        csrRead(14'h000, 5'd9, 32'h1C00_0300, 32'h0000_0008);
        csrRead(14'h006, 5'd9, 32'h1C00_0304, 32'h0000_0000);
        csrRead(14'h001, 5'd9, 32'h1C00_0308, 32'h0000_0000);
        csrRead(14'h031, 5'd9, 32'h1C00_030C, 32'h12FF_5600);
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        @(negedge clk);
        checkQuiet("idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage; consumes the memory-stage result bus.
- Commits GPR writes, forwards the committed value to decode, and emits debug trace signals.
- Owns the architectural CSR file: CRMD, PRMD, ESTAT, ERA, EENTRY, SAVE0-3.
- Performs CSR read/masked-write, exception entry and ERTN return, and drives the pipeline flush with its redirect target.

Parameters:
MS_TO_WS_BUS_WD, 167, width of incoming bus
WS_FWD_BUS_WD, 39, width of forward bus to decode

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ms_to_ws_valid  in  1  memory stage holds valid instruction
ms_to_ws_bus  in  167  {subecode[166:158], ex[157], ertn[156], csr_wvalue[155:124], ecode[123:118], csr_re[117], csr_we[116], csr_num[115:102], csr_wmask[101:70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}
ws_allowin  out  1  stage can accept
rf_we  out  1  GPR write enable
rf_waddr  out  5  GPR write index
rf_wdata  out  32  GPR write data
ws_fwd_bus  out  39  {csr_re&&ws_valid, ws_valid&&gr_we, dest, final_data}
ws_flush_pipe  out  1  flush all earlier stages
ws_flush_target  out  32  redirect PC
debug_wb_pc  out  32  committed PC
debug_wb_rf_we  out  4  byte write enable, all four bits equal rf_we
debug_wb_rf_wnum  out  5  = rf_waddr
debug_wb_rf_wdata  out  32  = rf_wdata

Behaviour:
Pipeline handshake
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- ws_ready_go=1 and ws_allowin=1 at all times.
- Register update: ws_valid<=ms_to_ws_valid every cycle. The bus is latched when ms_to_ws_valid.
- ws_valid resets to 0. With ws_valid=0, every enable/flush output is 0.
- The upstream stage already gates ms_to_ws_valid with ws_flush_pipe. This block relies on that and adds no gating of its own.

Commit and forwarding
- Define ex=ws_valid&&bus.ex and ertn=ws_valid&&bus.ertn&&!ex.
- rf_we = ws_valid && gr_we && !bus.ex.
- final_data = csr_re ? csr_rvalue : result.
- rf_wdata = final_data; rf_waddr = dest.

CSR read
- Combinational on csr_num:
  - 0x0 CRMD {28'b0, DA, IE, PLV[1:0]}
  - 0x1 PRMD {29'b0, PIE, PPLV[1:0]}
  - 0x5 ESTAT {1'b0, EsubCode[8:0], Ecode[5:0], 14'b0, IS[1:0]}
  - 0x6 ERA
  - 0xC EENTRY {VA[31:6], 6'b0}
  - 0x30-0x33 SAVE0-3
  - any other number reads 0.

CSR write
- Happens when ws_valid && csr_we && !bus.ex.
- Each implemented field is written as (old & ~wmask) | (wvalue & wmask), bit-aligned to the read layout.
- Read-only or unimplemented bits ignore writes. ESTAT writable bits are IS[1:0] only.

Reset values
- CRMD: PLV=0, IE=0, DA=1.
- PRMD, ESTAT, ERA and EENTRY: 0. SAVEn: undefined (not reset).

Exception entry (ex), priority over ertn and CSR write
- PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
- CRMD.PLV<=0; CRMD.IE<=0.
- ESTAT.Ecode<=ecode; ESTAT.EsubCode<=subecode.
- ERA<=pc.
- Flush target = EENTRY.

ERTN
- CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
- Flush target = ERA, using the value before any same-cycle update.

Flush
- ws_flush_pipe = ex||ertn, combinational, high for exactly the one cycle the instruction is in WB.
- ws_flush_target = 0 when ws_flush_pipe=0.

Same-cycle and boundary rules
- A CSR read in the same cycle as a write returns the old value.
- Register updates take effect at the next clock edge.
- If ex and csr_we are both set, only the exception updates occur.
- Reset mid-flush: ws_valid=0 on the next cycle and no CSR update occurs at that edge.

Debug
- debug_wb_pc = pc latched in the stage, valid regardless of ws_valid.

Test Plan:
- GPR commit:
  - Stimulus: valid, gr_we=1, dest=5, result=0x1234, csr_re=0.
  - Response: next cycle rf_we=1, waddr=5, wdata=0x1234, debug_wb_rf_we=4'hF, ws_fwd_bus[37]=1.
- CSR masked write then read:
  - Stimulus: write SAVE1 wvalue=0xFFFF0000 mask=0x00FF00FF (SAVE1 was 0x12345678); next instruction reads SAVE1 with gr_we=1.
  - Response: rf_wdata=0x12FF5600, ws_fwd_bus[38]=1.
- Exception entry:
  - Stimulus: CRMD=0x7 (DA=0, IE=1, PLV=3), EENTRY=0x1C000100, ex=1, ecode=0xB, subecode=0, pc=0x1C000040, gr_we=1.
  - Response: rf_we=0, flush=1, target=0x1C000100; then CRMD=0x0, PRMD=0x7, ERA=0x1C000040, ESTAT[21:16]=0xB.
- ERTN return:
  - Stimulus: from the previous state, ertn=1.
  - Response: flush=1, target=0x1C000040; then CRMD[2:0]=3'b111.
- Reset and edge cases:
  - Reset asserted: CRMD reads 0x8, all outputs 0.
  - ex and csr_we together: the CSR keeps its old value.
  - Read of unimplemented csr_num 0x7: returns 0.
  - ESTAT write of 0xFFFFFFFF with full mask: only IS bits change to 2'b11.
